// File: rtl/angle_sequencer.sv
// angle_sequencer: steps a horizontal/vertical angle pair while the user holds
// the forward button, and publishes the pair to the display at frame boundaries.
//
// The working registers wx/wy advance on every prescaler step. The published
// registers xangle/yangle are loaded only on frame_start, so the picture never
// changes in the middle of a frame.
//
// Optional feature: define ANGLE_SEQ_DEBOUNCE_EN to debounce the synchronized
// button. The level then changes only after 65536 consecutive stable cycles.
// With the macro undefined, the raw synchronizer output is used directly.
module angle_sequencer #(
    parameter int PRESCALE = 1000000,
    parameter int XMAX     = 180,
    parameter int YSTEP    = 90,
    parameter int YMAX     = 270,
    parameter int AW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          forward,
    input  logic          frame_start,
    output logic [AW-1:0] xangle,
    output logic [AW-1:0] yangle,
    output logic          angle_update
);

    // Keep the prescaler at least one bit wide, even for PRESCALE == 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [AW-1:0] X_LAST   = AW'(XMAX - 1);
    localparam logic [AW-1:0] Y_STEP   = AW'(YSTEP);
    // wy values above this one would exceed YMAX after the add.
    // The comparison is therefore made on wy before adding.
    localparam logic [AW-1:0] Y_WRAP   = AW'(YMAX - YSTEP);

    logic          sync_a;
    logic          sync_b;
    logic          fwd_s;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_nxt;
    logic          step;
    logic [AW-1:0] wx;
    logic [AW-1:0] wy;
    logic [AW-1:0] wx_nxt;
    logic [AW-1:0] wy_nxt;
    logic          changed;

    // Two-flop synchronizer for the asynchronous forward button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= forward;
            sync_b <= sync_a;
        end
    end

`ifdef ANGLE_SEQ_DEBOUNCE_EN
    logic [15:0] stable_cnt;
    logic        deb_level;

    // Debounce: adopt the synchronized level only after 65536 cycles in which
    // it differs from the current level. Any return to the current level
    // restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= 16'd0;
            deb_level  <= 1'b0;
        end else if (sync_b == deb_level) begin
            stable_cnt <= 16'd0;
        end else if (stable_cnt == 16'hFFFF) begin
            stable_cnt <= 16'd0;
            deb_level  <= sync_b;
        end else begin
            stable_cnt <= stable_cnt + 16'd1;
        end
    end

    assign fwd_s = deb_level;
`else
    assign fwd_s = sync_b;
`endif

    // Prescaler next state: count only while the button is held, and emit a
    // step on the terminal count.
    always_comb begin
        prescaler_nxt = prescaler;
        step          = 1'b0;
        if (fwd_s) begin
            if (prescaler == PRE_LAST) begin
                prescaler_nxt = '0;
                step          = 1'b1;
            end else begin
                prescaler_nxt = prescaler + PW'(1);
            end
        end else begin
            prescaler_nxt = prescaler;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler_nxt;
        end
    end

    // Working angle next state. wy moves only when wx wraps. Both limits are
    // tested before the add, so neither value can overshoot its limit.
    always_comb begin
        wx_nxt = wx;
        wy_nxt = wy;
        if (step) begin
            if (wx == X_LAST) begin
                wx_nxt = '0;
                if (wy > Y_WRAP) begin
                    wy_nxt = '0;
                end else begin
                    wy_nxt = wy + Y_STEP;
                end
            end else begin
                wx_nxt = wx + AW'(1);
                wy_nxt = wy;
            end
        end else begin
            wx_nxt = wx;
            wy_nxt = wy;
        end
    end

    // Working angle registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wx <= '0;
            wy <= '0;
        end else begin
            wx <= wx_nxt;
            wy <= wy_nxt;
        end
    end

    // Detect whether a publish would alter what the display currently shows.
    always_comb begin
        changed = 1'b0;
        if ((wx != xangle) || (wy != yangle)) begin
            changed = 1'b1;
        end else begin
            changed = 1'b0;
        end
    end

    // Publish the working angles at the frame boundary. Nonblocking
    // assignment means a coincident step is published on the next frame
    // rather than lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xangle       <= '0;
            yangle       <= '0;
            angle_update <= 1'b0;
        end else if (frame_start) begin
            xangle       <= wx;
            yangle       <= wy;
            angle_update <= changed;
        end else begin
            angle_update <= 1'b0;
        end
    end

endmodule

// File: doc/angle_sequencer.md
ANGLE_SEQUENCER -- requirements
Module: angle_sequencer

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 1000000, meaning clock cycles per angle step.
REQ-002 The module SHALL have parameter XMAX, default 180, meaning the wrap limit for xangle.
REQ-003 The module SHALL have parameter YSTEP, default 90, meaning the yangle increment applied on each xangle wrap.
REQ-004 The module SHALL have parameter YMAX, default 270, meaning the largest legal yangle.
REQ-005 The module SHALL have parameter AW, default 11, meaning the width of each angle output.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single system clock.
REQ-007 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-008 Port forward SHALL be an input, 1 bit wide: asynchronous user button; while held, angles advance.
REQ-009 Port frame_start SHALL be an input, 1 bit wide: one-cycle pulse from vga at h_count=0, v_count=0.
REQ-010 Port xangle SHALL be an output, AW bits wide: published horizontal angle, 0..XMAX-1.
REQ-011 Port yangle SHALL be an output, AW bits wide: published vertical angle, a multiple of YSTEP no greater than YMAX.
REQ-012 Port angle_update SHALL be an output, 1 bit wide: one-cycle pulse when the published angles change.

Function
REQ-013 forward SHALL pass through a 2-flop synchronizer before any use; the synchronized signal is fwd_s.
REQ-014 A prescaler counter of ceil(log2(PRESCALE)) bits SHALL count only while fwd_s=1; it holds its value while fwd_s=0.
REQ-015 When the prescaler equals PRESCALE-1, it SHALL reset to 0 and generate a one-cycle step pulse.
REQ-016 On a step pulse, working register wx SHALL increment by 1; if wx=XMAX-1, wx SHALL become 0 instead.
REQ-017 On the step pulse where wx wraps, working register wy SHALL add YSTEP; if wy+YSTEP>YMAX, wy SHALL become 0 instead.
REQ-018 wy SHALL change only on an xangle wrap, never on any other step.
REQ-019 On a frame_start pulse, xangle/yangle SHALL load wx/wy in the same clock edge, so the outputs change at most once per frame.
REQ-020 When a step and frame_start occur in the same cycle, the outputs SHALL receive the pre-step wx/wy and the step SHALL update the working registers, losing no step.
REQ-021 Multiple steps between frame_start pulses SHALL all accumulate in wx/wy; at the next frame only the final value is published.
REQ-022 angle_update SHALL assert for exactly one cycle, the cycle after a frame_start load in which {wx,wy} differed from {xangle,yangle}; it SHALL stay 0 otherwise.
REQ-023 Latency SHALL be: step pulse to visible output no more than one frame, plus 1 cycle; frame_start to angle_update exactly 1 cycle.
REQ-024 All arithmetic SHALL be unsigned AW-bit; the wrap comparisons SHALL be made before the add, so the result never exceeds its limit.

Reset
REQ-025 While rst=1, and asynchronously on assertion: prescaler, wx, wy, xangle, yangle and angle_update SHALL all be 0, and the synchronizer flops SHALL be 0.
REQ-026 Reset asserted mid-step or mid-frame SHALL discard the pending working values, with no publish at the next frame_start unless a step has occurred.
REQ-027 After rst deasserts, the first step SHALL require a full PRESCALE cycles of fwd_s=1.

Configuration
REQ-028 When macro ANGLE_SEQ_DEBOUNCE_EN is defined, fwd_s SHALL be replaced by a debounced level: it changes only after the synchronized input is stable for 65536 consecutive cycles, using a 16-bit stable counter that is reset to 0 by rst.
REQ-029 Without ANGLE_SEQ_DEBOUNCE_EN, fwd_s SHALL be the raw 2-flop synchronizer output, and no debounce logic SHALL be synthesized.

Verification
REQ-030 Reset test: assert rst mid-count with wx=5; the outputs SHALL read 0 immediately (asynchronously) and angle_update SHALL be 0.
REQ-031 Step test: PRESCALE=4, forward held; after the sync delay plus 4 cycles wx=1, and the next frame_start yields xangle=1 and an angle_update pulse 1 cycle later.
REQ-032 Wrap test: PRESCALE=1, XMAX=180, forward held for 180 steps from 0; wx SHALL be 0 and wy SHALL be 90; with wy=270, the next wrap SHALL give wy=0.
REQ-033 Simultaneous-event test: a step and frame_start in the same cycle with wx=7; xangle SHALL be 7 and wx SHALL be 8, and the next frame SHALL publish 8.
REQ-034 Hold test: forward released with the prescaler at 2; wait 100 cycles and re-press; the step SHALL occur PRESCALE-2 cycles of fwd_s=1 later, and frame_start with no change SHALL give no angle_update.
REQ-035 Debounce test: with ANGLE_SEQ_DEBOUNCE_EN defined, a 1000-cycle glitch on forward SHALL produce no step and no prescaler change.
